ram_readout: RTL

//  Downstream of the acquisition stage. After acquisition fills the sample RAM and the

---
 rtl/ram_readout.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/ram_readout.sv
`default_nettype none
// ============================================================================
//  Module      : ram_readout
//  Description : Dumps the whole sample RAM, in address order, onto a
//                valid/ready byte stream towards the host link, then pulses
//                done_rd so the arbiter can release the RAM.
//                Optional feature macro: READOUT_CKSUM_EN
//                  defined   -> one extra trailing byte, the mod-2**DATA_W sum
//                               of all DEPTH data bytes, before done_rd.
//                  undefined -> exactly DEPTH bytes, then done_rd.
//  Ports       : clk       clock
//                rst       asynchronous active-high reset
//                grant_rd  arbiter grant (level, only looked at in IDLE)
//                done_rd   one-cycle completion pulse
//                busy      high whenever a dump is in progress
//                rd_addr   RAM read address (registered)
//                rd_en     RAM read strobe, data returns one cycle later
//                rd_data   RAM read data
//                tx_data   stream byte (registered)
//                tx_valid  stream byte valid
//                tx_ready  sink ready; transfer on tx_valid & tx_ready
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_readout #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grant_rd,
    output logic              done_rd,
    output logic              busy,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    // Last RAM location of the dump; rd_addr stops here and never wraps.
    localparam logic [ADDR_W-1:0] c_LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_SEND  = 3'd3,
`ifdef READOUT_CKSUM_EN
        S_CKSUM = 3'd4,
`endif
        S_DONE  = 3'd5
    } state_t;

    state_t r_state;

`ifdef READOUT_CKSUM_EN
    logic [DATA_W-1:0] r_cksum;
    logic [DATA_W-1:0] w_cksum_next;

    // Running sum including the byte being handed over this cycle.
    assign w_cksum_next = r_cksum + tx_data;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            rd_addr  <= '0;
            rd_en    <= 1'b0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            done_rd  <= 1'b0;
            busy     <= 1'b0;
`ifdef READOUT_CKSUM_EN
            r_cksum  <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (grant_rd) begin
                        r_state <= S_FETCH;
                        rd_addr <= '0;
                        rd_en   <= 1'b1;   // strobe is visible during FETCH
                        busy    <= 1'b1;
`ifdef READOUT_CKSUM_EN
                        r_cksum <= '0;
`endif
                    end
                end

                S_FETCH: begin
                    rd_en   <= 1'b0;
                    r_state <= S_LATCH;
                end

                S_LATCH: begin
                    // RAM output is valid now, one cycle after the strobe.
                    tx_data  <= rd_data;
                    tx_valid <= 1'b1;
                    r_state  <= S_SEND;
                end

                S_SEND: begin
                    if (tx_ready) begin
`ifdef READOUT_CKSUM_EN
                        r_cksum <= w_cksum_next;
`endif
                        if (rd_addr == c_LAST_ADDR) begin
`ifdef READOUT_CKSUM_EN
                            // Checksum byte follows immediately, no bubble.
                            tx_data  <= w_cksum_next;
                            tx_valid <= 1'b1;
                            r_state  <= S_CKSUM;
`else
                            tx_valid <= 1'b0;
                            done_rd  <= 1'b1;
                            r_state  <= S_DONE;
`endif
                        end else begin
                            tx_valid <= 1'b0;
                            rd_addr  <= rd_addr + c_ADDR_ONE;
                            rd_en    <= 1'b1;
                            r_state  <= S_FETCH;
                        end
                    end
                end

`ifdef READOUT_CKSUM_EN
                S_CKSUM: begin
                    if (tx_ready) begin
                        tx_valid <= 1'b0;
                        done_rd  <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    done_rd <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    rd_en    <= 1'b0;
                    tx_valid <= 1'b0;
                    done_rd  <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
